// File: rtl/imem_dmem_arbiter.sv
// Single-port memory arbiter shared by instruction fetch, data access and a debug/loader port.
// One grant per cycle, 1-cycle read latency, exclusive DBG lock that holds the CPU pipeline.
module imem_dmem_arbiter #(
  parameter int AW           = 10,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk1,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_gnt,
  output logic          dm_rvalid,
  output logic [DW-1:0] dm_rdata,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  input  logic          dbg_lock,
  output logic          dbg_gnt,
  output logic          dbg_rvalid,
  output logic [DW-1:0] dbg_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          cpu_hold
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic {S_NORMAL, S_LOCKED} state_e;
  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_DM, OWN_DBG} owner_e;

  state_e        r_state, w_state_nxt;
  owner_e        r_owner, w_owner_nxt;
  logic [SW-1:0] r_starve, w_starve_nxt;
  logic [DW-1:0] r_if_hold, r_dm_hold, r_dbg_hold;
  logic          w_if_promote;

  assign w_if_promote = (r_starve == SW'(STARVE_LIMIT)) && if_req;

  // Grant decision and memory-side mux.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    if_gnt    = 1'b0;
    dm_gnt    = 1'b0;
    dbg_gnt   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (!rst) begin
      if (dbg_req) begin
        dbg_gnt = 1'b1;
      end else if (r_state == S_NORMAL) begin
        if (w_if_promote)  if_gnt = 1'b1;
        else if (dm_req)   dm_gnt = 1'b1;
        else if (if_req)   if_gnt = 1'b1;
      end
    end
    if (dbg_gnt) begin
      mem_we    = dbg_we;
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
    end else if (dm_gnt) begin
      mem_we    = dm_we;
      mem_addr  = dm_addr;
      mem_wdata = dm_wdata;
    end else if (if_gnt) begin
      mem_addr  = if_addr;
    end
  end

  assign mem_en = if_gnt | dm_gnt | dbg_gnt;

  always_comb begin
    w_owner_nxt  = OWN_NONE;
    w_state_nxt  = r_state;
    w_starve_nxt = r_starve;
    if (dbg_gnt && !dbg_we)     w_owner_nxt = OWN_DBG;
    else if (dm_gnt && !dm_we)  w_owner_nxt = OWN_DM;
    else if (if_gnt)            w_owner_nxt = OWN_IF;

    case (r_state)
      S_NORMAL: begin
        if (dbg_gnt && dbg_lock) w_state_nxt = S_LOCKED;
        if (if_req && !if_gnt) begin
          if (r_starve != SW'(STARVE_LIMIT)) w_starve_nxt = r_starve + 1'b1;
        end else begin
          w_starve_nxt = '0;
        end
      end
      S_LOCKED: begin
        if (!dbg_lock) w_state_nxt = S_NORMAL;
      end
      default: w_state_nxt = S_NORMAL;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk1) begin
    if (rst) begin
      r_state  <= S_NORMAL;
      r_owner  <= OWN_NONE;
      r_starve <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_owner  <= w_owner_nxt;
      r_starve <= w_starve_nxt;
    end
  end

  assign if_rvalid  = !rst && (r_owner == OWN_IF);
  assign dm_rvalid  = !rst && (r_owner == OWN_DM);
  assign dbg_rvalid = !rst && (r_owner == OWN_DBG);
  assign cpu_hold   = !rst && (r_state == S_LOCKED);

  // NOTE: the read-data hold registers are pure datapath and carry no reset; rvalid qualifies them.
  always_ff @(posedge clk1) begin
    if (if_rvalid)  r_if_hold  <= mem_rdata;
    if (dm_rvalid)  r_dm_hold  <= mem_rdata;
    if (dbg_rvalid) r_dbg_hold <= mem_rdata;
  end

  assign if_rdata  = if_rvalid  ? mem_rdata : r_if_hold;
  assign dm_rdata  = dm_rvalid  ? mem_rdata : r_dm_hold;
  assign dbg_rdata = dbg_rvalid ? mem_rdata : r_dbg_hold;

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Randomized and directed bench for imem_dmem_arbiter against a rule-level reference model
// with a synchronous RAM and a shadow memory image.
module tb_imem_dmem_arbiter;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int LIM = 4;

  typedef struct {
    logic          rst;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          dm_req, dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic          dbg_req, dbg_we, dbg_lock;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_wdata;
  } stim_t;

  logic clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  logic          rst, if_req, dm_req, dm_we, dbg_req, dbg_we, dbg_lock;
  logic [AW-1:0] if_addr, dm_addr, dbg_addr, mem_addr;
  logic [DW-1:0] dm_wdata, dbg_wdata, mem_wdata, mem_rdata;
  logic          if_gnt, if_rvalid, dm_gnt, dm_rvalid, dbg_gnt, dbg_rvalid;
  logic [DW-1:0] if_rdata, dm_rdata, dbg_rdata;
  logic          mem_en, mem_we, cpu_hold;

  imem_dmem_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(LIM)) dut (
    .clk1(clk1), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_lock(dbg_lock), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .cpu_hold(cpu_hold)
  );

  // Synchronous RAM behind the arbiter.
  logic [DW-1:0] ram [1 << AW];
  always @(posedge clk1) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  // Reference model state: 0 = none, 1 = IF, 2 = DM, 3 = DBG.
  logic [DW-1:0] ref_mem [1 << AW];
  bit            m_locked;
  int            m_starve;
  int            m_pend;
  logic [DW-1:0] m_pend_data;
  logic [DW-1:0] m_last [1:3];
  bit            m_has_last [1:3];

  int    n_vec, n_err;
  stim_t st;
  int    last_g;
  logic [DW-1:0] obs_rdata [1:3];
  logic          obs_rvalid [1:3];

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle();
    st = '{rst: 1'b0, if_req: 1'b0, if_addr: '0, dm_req: 1'b0, dm_we: 1'b0, dm_addr: '0,
           dm_wdata: '0, dbg_req: 1'b0, dbg_we: 1'b0, dbg_lock: 1'b0, dbg_addr: '0, dbg_wdata: '0};
  endtask

  task automatic cycle();
    int g;
    logic          e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    @(negedge clk1);
    rst = st.rst; if_req = st.if_req; if_addr = st.if_addr;
    dm_req = st.dm_req; dm_we = st.dm_we; dm_addr = st.dm_addr; dm_wdata = st.dm_wdata;
    dbg_req = st.dbg_req; dbg_we = st.dbg_we; dbg_lock = st.dbg_lock;
    dbg_addr = st.dbg_addr; dbg_wdata = st.dbg_wdata;
    #1;
    // Winner from the priority rules.
    g = 0;
    if (!st.rst) begin
      if (st.dbg_req) g = 3;
      else if (!m_locked) begin
        if (m_starve == LIM && st.if_req) g = 1;
        else if (st.dm_req)               g = 2;
        else if (st.if_req)               g = 1;
      end
    end
    e_we = 1'b0; e_addr = '0; e_wdata = '0;
    if (g == 3) begin e_we = st.dbg_we; e_addr = st.dbg_addr; e_wdata = st.dbg_wdata; end
    if (g == 2) begin e_we = st.dm_we;  e_addr = st.dm_addr;  e_wdata = st.dm_wdata;  end
    if (g == 1) e_addr = st.if_addr;
    check("if_gnt", if_gnt, g == 1);
    check("dm_gnt", dm_gnt, g == 2);
    check("dbg_gnt", dbg_gnt, g == 3);
    check("mem_en", mem_en, g != 0);
    check("mem_we", mem_we, e_we);
    check("mem_addr", mem_addr, e_addr);
    check("mem_wdata", mem_wdata, e_wdata);
    check("cpu_hold", cpu_hold, !st.rst && m_locked);
    obs_rvalid[1] = if_rvalid;  obs_rdata[1] = if_rdata;
    obs_rvalid[2] = dm_rvalid;  obs_rdata[2] = dm_rdata;
    obs_rvalid[3] = dbg_rvalid; obs_rdata[3] = dbg_rdata;
    for (int p = 1; p <= 3; p++) begin
      bit ev;
      ev = !st.rst && (m_pend == p);
      check($sformatf("rvalid%0d", p), obs_rvalid[p], ev);
      if (ev) begin
        check($sformatf("rdata%0d", p), obs_rdata[p], m_pend_data);
        m_last[p] = m_pend_data;
        m_has_last[p] = 1'b1;
      end else if (m_has_last[p]) begin
        check($sformatf("rhold%0d", p), obs_rdata[p], m_last[p]);
      end
    end
    last_g = g;
    @(posedge clk1);
    if (st.rst) begin
      m_locked = 1'b0; m_starve = 0; m_pend = 0;
    end else begin
      m_pend = 0;
      if (g != 0) begin
        if (e_we) ref_mem[e_addr] = e_wdata;
        else begin m_pend = g; m_pend_data = ref_mem[e_addr]; end
      end
      if (!m_locked) begin
        if (st.if_req && g != 1) m_starve = (m_starve < LIM) ? m_starve + 1 : LIM;
        else                     m_starve = 0;
        if (g == 3 && st.dbg_lock) m_locked = 1'b1;
      end else if (!st.dbg_lock) begin
        m_locked = 1'b0;
      end
    end
  endtask

  initial begin
    n_vec = 0; n_err = 0; m_locked = 0; m_starve = 0; m_pend = 0; m_pend_data = '0;
    for (int p = 1; p <= 3; p++) begin m_last[p] = '0; m_has_last[p] = 1'b0; end
    for (int i = 0; i < (1 << AW); i++) begin
      ram[i]     = 32'h1000_0000 + i * 32'h3;
      ref_mem[i] = 32'h1000_0000 + i * 32'h3;
    end
    ram[5] = 32'h1234; ref_mem[5] = 32'h1234;

    // Reset with every requester active.
    idle();
    st.rst = 1; st.if_req = 1; st.dm_req = 1; st.dbg_req = 1;
    cycle(); cycle();
    check("rst_no_grant", {29'b0, dbg_gnt, dm_gnt, if_gnt}, 0);
    st.rst = 0;
    cycle();
    check("post_rst_dbg_first", last_g, 3);

    // DM beats IF; read data one cycle later.
    idle(); cycle();
    st.if_req = 1; st.dm_req = 1; st.dm_addr = 5;
    cycle();
    check("pri_dm_gnt", last_g, 2);
    idle(); cycle();
    check("pri_dm_rvalid", obs_rvalid[2], 1);
    check("pri_dm_rdata", obs_rdata[2], 32'h1234);
    check("pri_if_rvalid", obs_rvalid[1], 0);

    // Starvation: DM x4, IF, DM.
    idle(); cycle();
    st.if_req = 1; st.if_addr = 3; st.dm_req = 1; st.dm_addr = 7;
    for (int k = 1; k <= 6; k++) begin
      cycle();
      check($sformatf("starve_c%0d", k), last_g, (k == 5) ? 1 : 2);
    end

    // Program load under lock with IF requesting throughout.
    idle();
    st.if_req = 1; st.dbg_req = 1; st.dbg_lock = 1; st.dbg_we = 1;
    st.dbg_addr = 200; st.dbg_wdata = 32'hAAAA;
    cycle();
    st.dbg_we = 0; cycle();
    check("lock_hold", cpu_hold, 1);
    st.dbg_req = 0; cycle();
    check("lock_dbg_rdata", obs_rdata[3], 32'hAAAA);
    check("lock_if_gnt", if_gnt, 0);
    st.dbg_lock = 0; cycle();
    check("exit_hold_still", cpu_hold, 1);
    cycle();
    check("unlock_hold", cpu_hold, 0);
    check("unlock_if_gnt", last_g, 1);

    // CPU store then DBG readback.
    idle(); st.dm_req = 1; st.dm_we = 1; st.dm_addr = 198; st.dm_wdata = 5040; cycle();
    idle(); st.dbg_req = 1; st.dbg_addr = 198; cycle();
    idle(); cycle();
    check("readback", obs_rdata[3], 5040);

    // Reset right after a DM read grant.
    idle(); st.dm_req = 1; st.dm_addr = 9; cycle();
    idle(); st.rst = 1; cycle();
    check("rst_mid_rvalid", obs_rvalid[2], 0);
    idle(); cycle();
    check("rst_mid_normal", cpu_hold, 0);

    // Randomized traffic; ungranted requests usually stay stable.
    idle();
    for (int n = 0; n < 3000; n++) begin
      bit keep_if, keep_dm, keep_dbg;
      keep_if  = st.if_req  && last_g != 1 && ($urandom_range(4) != 0);
      keep_dm  = st.dm_req  && last_g != 2 && ($urandom_range(4) != 0);
      keep_dbg = st.dbg_req && last_g != 3 && ($urandom_range(4) != 0);
      st.rst = ($urandom_range(99) == 0);
      if (!keep_if) begin
        st.if_req = $urandom_range(2) != 0; st.if_addr = AW'($urandom_range(15));
      end
      if (!keep_dm) begin
        st.dm_req = $urandom_range(1); st.dm_we = $urandom_range(1);
        st.dm_addr = ($urandom_range(7) == 0) ? AW'($urandom) : AW'($urandom_range(15));
        st.dm_wdata = $urandom;
      end
      if (!keep_dbg) begin
        st.dbg_req = ($urandom_range(5) == 0); st.dbg_we = $urandom_range(1);
        st.dbg_addr = AW'($urandom_range(15)); st.dbg_wdata = $urandom;
      end
      if ($urandom_range(7) == 0) st.dbg_lock = ~st.dbg_lock;
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
